// File: rtl/dsp_result_drain.sv
// ---------------------------------------------------------------------------
// dsp_result_drain
//
// Result-side companion to a DSP slice pipeline. Tracks which CE-gated slice
// stages hold valid operations, captures each finished result from the slice
// P output into a small show-ahead FIFO, and presents results downstream over
// a valid/ready handshake. When the FIFO cannot absorb the result sitting at
// the last stage, the shared slice clock enable is dropped, which freezes
// every slice register without losing data.
//
// Ports:
//   clk       clock
//   reset     asynchronous, active-high; clears all state
//   in_valid  an operation is presented on the slice operand inputs
//   in_ready  issue accepted this cycle (equals pipe_ce)
//   pipe_ce   clock enable for every slice pipeline register
//   p_in      slice last-stage result, valid when vpipe[LATENCY-1]=1
//   m_valid   m_data holds a result
//   m_ready   consumer accepts m_data
//   m_data    oldest unread result (show-ahead)
//   count     FIFO occupancy
// ---------------------------------------------------------------------------
module dsp_result_drain #(
   parameter int WIDTH   = 48,
   parameter int LATENCY = 3,
   parameter int DEPTH   = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       pipe_ce,
   input  logic [WIDTH-1:0]           p_in,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [WIDTH-1:0]           m_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [LATENCY-1:0] vpipe;
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [WIDTH-1:0]   mem [DEPTH];
   logic               push;
   logic               pop;
   logic               room;

   // A pop frees a slot in the same cycle, so a full FIFO being read can
   // still accept the last-stage result; this is why m_ready reaches pipe_ce
   // combinationally.
   assign pop      = m_valid & m_ready;
   assign room     = (count < FULL) | pop;
   assign pipe_ce  = ~(vpipe[LATENCY-1] & ~room);
   assign in_ready = pipe_ce;

   // p_in is frozen while pipe_ce=0, so a stalled result is written exactly
   // once, on the edge where the stall releases.
   assign push     = vpipe[LATENCY-1] & pipe_ce;

   assign m_valid  = (count != '0);
   assign m_data   = mem[rd_ptr];

   // Valid shadow of the slice pipeline; advances only with the slice CE.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its neighbour, exactly like the hardware.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vpipe <= '0;
      end else if (pipe_ce) begin
         vpipe[0] <= in_valid;
         for (int i = 1; i < LATENCY; i++) begin
            vpipe[i] <= vpipe[i-1];
         end
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: the storage array is reset so m_data reads a defined zero from
   // mem[0] after reset; with only a handful of entries this costs little.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= p_in;
      end
   end

endmodule

// File: tb/tb_dsp_result_drain.sv
// ---------------------------------------------------------------------------
// tb_dsp_result_drain
//
// Self-checking bench for dsp_result_drain (WIDTH=48, LATENCY=3, DEPTH=4).
// The bench plays the role of the DSP slice: a CE-gated data pipeline whose
// last stage drives p_in. A behavioural reference keeps the in-flight ops in
// per-stage slots and the buffered results in a queue, and predicts pipe_ce,
// m_valid, m_data and count every cycle. Issued and popped values are also
// recorded so end-to-end ordering can be checked per scenario.
// ---------------------------------------------------------------------------
module tb_dsp_result_drain;

   localparam int W   = 48;
   localparam int LAT = 3;
   localparam int DEP = 4;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic          pipe_ce;
   logic [W-1:0]  p_in;
   logic          m_valid;
   logic          m_ready;
   logic [W-1:0]  m_data;
   logic [2:0]    count;

   dsp_result_drain #(.WIDTH(W), .LATENCY(LAT), .DEPTH(DEP)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .pipe_ce  (pipe_ce),
      .p_in     (p_in),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model / slice emulation
   logic         sv [LAT];
   logic [W-1:0] sd [LAT];
   logic [W-1:0] fifo_q   [$];
   logic [W-1:0] issued_q [$];
   logic [W-1:0] got_q    [$];
   int           pop_cyc  [$];
   int           stall_cycles;
   int           max_count;

   task automatic model_clear();
      for (int i = 0; i < LAT; i++) begin
         sv[i] = 1'b0;
         sd[i] = '0;
      end
      fifo_q.delete();
      issued_q.delete();
      got_q.delete();
      pop_cyc.delete();
      stall_cycles = 0;
      max_count    = 0;
   endtask

   // One clock cycle: drive at negedge, compare against the model, then
   // advance the model on the rising edge.
   task automatic step(input logic iv, input logic [W-1:0] val, input logic mr);
      logic exp_ce;
      int   sz;
      @(negedge clk);
      in_valid = iv;
      m_ready  = mr;
      p_in     = sd[LAT-1];
      #1;
      sz     = fifo_q.size();
      exp_ce = !(sv[LAT-1] && sz == DEP && !(sz != 0 && mr));
      n_cmp++;
      if (pipe_ce !== exp_ce) begin
         n_err++;
         $display("FAIL pipe_ce cyc %0d: got %b expected %b", cyc, pipe_ce, exp_ce);
      end
      n_cmp++;
      if (in_ready !== exp_ce) begin
         n_err++;
         $display("FAIL in_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_ce);
      end
      n_cmp++;
      if (m_valid !== (sz != 0)) begin
         n_err++;
         $display("FAIL m_valid cyc %0d: got %b expected %b", cyc, m_valid, sz != 0);
      end
      n_cmp++;
      if (count !== sz[2:0]) begin
         n_err++;
         $display("FAIL count cyc %0d: got %0d expected %0d", cyc, count, sz);
      end
      if (sz != 0) begin
         n_cmp++;
         if (m_data !== fifo_q[0]) begin
            n_err++;
            $display("FAIL m_data cyc %0d: got %h expected %h", cyc, m_data, fifo_q[0]);
         end
      end
      if (pipe_ce !== 1'b1) stall_cycles++;
      if (int'(count) > max_count) max_count = int'(count);
      if (m_valid === 1'b1 && mr) begin
         got_q.push_back(m_data);
         pop_cyc.push_back(cyc);
      end
      if (iv && exp_ce) issued_q.push_back(val);
      @(posedge clk);
      if (sz != 0 && mr) void'(fifo_q.pop_front());
      if (exp_ce) begin
         if (sv[LAT-1]) fifo_q.push_back(sd[LAT-1]);
         for (int i = LAT-1; i > 0; i--) begin
            sv[i] = sv[i-1];
            sd[i] = sd[i-1];
         end
         sv[0] = iv;
         sd[0] = val;
      end
      cyc++;
      #1;
   endtask

   // Asynchronous reset: asserted mid-cycle, outputs checked before any edge.
   task automatic do_reset();
      #2;
      reset    = 1'b1;
      in_valid = 1'b0;
      m_ready  = 1'b0;
      #1;
      n_cmp++;
      if (m_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_m_valid: got %b expected 0", m_valid);
      end
      n_cmp++;
      if (count !== 3'd0) begin
         n_err++;
         $display("FAIL reset_count: got %0d expected 0", count);
      end
      n_cmp++;
      if (pipe_ce !== 1'b1 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ce: got pipe_ce=%b in_ready=%b expected 1/1", pipe_ce, in_ready);
      end
      n_cmp++;
      if (m_data !== '0) begin
         n_err++;
         $display("FAIL reset_m_data: got %h expected 0", m_data);
      end
      model_clear();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_single_op();
      model_clear();
      step(1'b1, 48'h0000_1234_5678, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      // Before edge 3 nothing is visible yet; m_ready is dropped for one
      // cycle so the result can be inspected after edge 3.
      step(1'b0, '0, 1'b0);
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== 48'h0000_1234_5678) begin
         n_err++;
         $display("FAIL single_out: got v=%b d=%h expected v=1 d=000012345678", m_valid, m_data);
      end
      step(1'b0, '0, 1'b1);
      n_cmp++;
      if (count !== 3'd0 || m_valid !== 1'b0) begin
         n_err++;
         $display("FAIL single_pop: got count=%0d v=%b expected 0/0", count, m_valid);
      end
      n_cmp++;
      if (stall_cycles != 0) begin
         n_err++;
         $display("FAIL single_ce: got %0d stall cycles expected 0", stall_cycles);
      end
   endtask

   task automatic test_back_to_back();
      model_clear();
      for (int i = 1; i <= 16; i++) step(1'b1, 48'(i), 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
      n_cmp++;
      if (got_q.size() != 16) begin
         n_err++;
         $display("FAIL stream_n: got %0d results expected 16", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < 16; i++) begin
         n_cmp++;
         if (got_q[i] !== 48'(i+1) || pop_cyc[i] != pop_cyc[0] + i) begin
            n_err++;
            $display("FAIL stream_%0d: got %h at cyc %0d expected %h at cyc %0d",
                     i, got_q[i], pop_cyc[i], 48'(i+1), pop_cyc[0] + i);
         end
      end
      n_cmp++;
      if (max_count > 1 || stall_cycles != 0) begin
         n_err++;
         $display("FAIL stream_flow: got max_count=%0d stalls=%0d expected <=1/0", max_count, stall_cycles);
      end
   endtask

   task automatic test_backpressure();
      model_clear();
      for (int i = 1; i <= 6; i++) step(1'b1, 48'(i), 1'b0);
      step(1'b0, '0, 1'b0);   // 4th result pushed, FIFO now full
      step(1'b0, '0, 1'b0);   // 5th result at last stage: stalled
      step(1'b0, '0, 1'b0);
      n_cmp++;
      if (pipe_ce !== 1'b0 || count !== 3'd4) begin
         n_err++;
         $display("FAIL bp_stall: got pipe_ce=%b count=%0d expected 0/4", pipe_ce, count);
      end
      n_cmp++;
      if (stall_cycles != 2) begin
         n_err++;
         $display("FAIL bp_stall_len: got %0d stall cycles expected 2", stall_cycles);
      end
      step(1'b0, '0, 1'b1);   // release: push and pop on the same edge
      n_cmp++;
      if (count !== 3'd4) begin
         n_err++;
         $display("FAIL bp_release: got count=%0d expected 4", count);
      end
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
      n_cmp++;
      if (got_q.size() != 6 || count !== 3'd0) begin
         n_err++;
         $display("FAIL bp_n: got %0d results count=%0d expected 6/0", got_q.size(), count);
      end
      for (int i = 0; i < got_q.size() && i < 6; i++) begin
         n_cmp++;
         if (got_q[i] !== 48'(i+1)) begin
            n_err++;
            $display("FAIL bp_%0d: got %h expected %h", i, got_q[i], 48'(i+1));
         end
      end
   endtask

   task automatic test_full_pop();
      model_clear();
      for (int i = 1; i <= 5; i++) step(1'b1, 48'(16'hF00 + i), 1'b0);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0);   // count=4, 5th result now at the last stage
      n_cmp++;
      if (count !== 3'd4) begin
         n_err++;
         $display("FAIL fp_fill: got count=%0d expected 4", count);
      end
      step(1'b0, '0, 1'b1);   // step() checks pipe_ce=1 here
      n_cmp++;
      if (count !== 3'd4 || stall_cycles != 0) begin
         n_err++;
         $display("FAIL fp_pop: got count=%0d stalls=%0d expected 4/0", count, stall_cycles);
      end
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
   endtask

   task automatic test_bubbles();
      model_clear();
      for (int i = 0; i < 20; i++) step(i % 2 == 0, 48'(16'hB00 + i), 1'b0);
      n_cmp++;
      if (stall_cycles == 0 || count !== 3'd4) begin
         n_err++;
         $display("FAIL bub_full: got stalls=%0d count=%0d expected >0/4", stall_cycles, count);
      end
      for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);
      n_cmp++;
      if (got_q != issued_q) begin
         n_err++;
         $display("FAIL bub_order: got %0d results expected %0d in issue order", got_q.size(), issued_q.size());
      end
   endtask

   task automatic test_reset_midstream();
      model_clear();
      for (int i = 1; i <= 5; i++) step(1'b1, 48'(16'hA0 + i), 1'b0);
      step(1'b0, '0, 1'b0);   // count=3, two results in flight
      n_cmp++;
      if (count !== 3'd3) begin
         n_err++;
         $display("FAIL rm_setup: got count=%0d expected 3", count);
      end
      do_reset();
      step(1'b1, 48'hCAFE, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
      n_cmp++;
      if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== 48'hCAFE)) begin
         n_err++;
         $display("FAIL rm_after: got %0d results expected exactly one 00000000cafe", got_q.size());
      end
   endtask

   task automatic test_random();
      logic [W-1:0] v;
      model_clear();
      for (int i = 0; i < 400; i++) begin
         v = {16'($urandom), $urandom};
         step(($urandom % 3) != 0, v, ($urandom % 2) != 0);
      end
      for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);
      n_cmp++;
      if (got_q != issued_q || count !== 3'd0) begin
         n_err++;
         $display("FAIL rand_order: got %0d results count=%0d expected %0d in order, count 0",
                  got_q.size(), count, issued_q.size());
      end
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      m_ready  = 1'b0;
      p_in     = '0;
      model_clear();
      test_reset();
      test_single_op();
      test_back_to_back();
      test_backpressure();
      test_full_pop();
      test_bubbles();
      test_reset_midstream();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
